// File: rtl/cmp_arbiter.sv
// Two-requester front end for a shared 32-bit comparator: arbitrates, latches
// operands, captures the comparator result and returns it on a per-requester channel.
module cmp_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_s,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_s,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp0_lt,
  output logic        resp0_eq,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic        resp1_lt,
  output logic        resp1_eq,
  output logic [31:0] cmp_rs1d,
  output logic [31:0] cmp_rs2d,
  output logic        cmp_s,
  input  logic        cmp_lt,
  input  logic        cmp_eq,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a request transfers on a rising edge where reqN_valid & reqN_ready;
  // a response retires on a rising edge where respN_valid & respN_ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam bit FP = (FIXED_PRIO != 0);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_id_q, gnt_id_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic        s_q, s_d;
  logic [1:0]  lt_q, lt_d;
  logic [1:0]  eq_q, eq_d;

  logic win0, win1;
  logic grant_ok;
  logic hs;
  logic resp_accept;

  // Under contention the requester that did not win the last handshake goes next.
  always_comb begin
    win1 = 1'b0;
    if (req1_valid) begin
      if (!req0_valid) begin
        win1 = 1'b1;
      end else if (!FP) begin
        win1 = ~last_grant_q;
      end
    end
    win0 = req0_valid & ~win1;
  end

  assign grant_ok    = (state_q == IDLE) & reset_n;
  assign req0_ready  = grant_ok & win0;
  assign req1_ready  = grant_ok & win1;
  assign hs          = req0_ready | req1_ready;
  assign resp_accept = gnt_id_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    s_d          = s_q;
    lt_d         = lt_q;
    eq_d         = eq_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          rs1_d        = req1_ready ? req1_a : req0_a;
          rs2_d        = req1_ready ? req1_b : req0_b;
          s_d          = req1_ready ? req1_s : req0_s;
          gnt_id_d     = req1_ready;
          last_grant_d = req1_ready;
          state_d      = EVAL;
        end
      end
      EVAL: begin
        lt_d[gnt_id_q] = cmp_lt;
        eq_d[gnt_id_q] = cmp_eq;
        state_d        = RESP;
      end
      RESP: begin
        if (resp_accept) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      s_q          <= 1'b0;
      lt_q         <= '0;
      eq_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      s_q          <= s_d;
      lt_q         <= lt_d;
      eq_q         <= eq_d;
    end
  end

  assign resp0_valid = (state_q == RESP) & ~gnt_id_q;
  assign resp1_valid = (state_q == RESP) &  gnt_id_q;
  assign resp0_lt    = lt_q[0];
  assign resp0_eq    = eq_q[0];
  assign resp1_lt    = lt_q[1];
  assign resp1_eq    = eq_q[1];
  assign cmp_rs1d    = rs1_q;
  assign cmp_rs2d    = rs2_q;
  assign cmp_s       = s_q;
  assign busy        = reset_n & (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each with its own behavioural comparator; results checked against a reference model.
module tb_cmp_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_s = 1'b0, req1_s = 1'b0;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;

  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic        resp0_lt, resp0_eq, resp1_lt, resp1_eq, busy;
  logic [31:0] cmp_rs1d, cmp_rs2d;
  logic        cmp_s, cmp_lt, cmp_eq;
  logic [1:0]  dbg_state;

  logic        fp_req0_ready, fp_req1_ready, fp_resp0_valid, fp_resp1_valid;
  logic        fp_resp0_lt, fp_resp0_eq, fp_resp1_lt, fp_resp1_eq, fp_busy;
  logic [31:0] fp_rs1d, fp_rs2d;
  logic        fp_s, fp_lt, fp_eq;
  logic [1:0]  fp_dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  // Behavioural stand-ins for the shared comparator.
  assign cmp_eq = (cmp_rs1d == cmp_rs2d);
  assign cmp_lt = cmp_s ? ($signed(cmp_rs1d) < $signed(cmp_rs2d)) : (cmp_rs1d < cmp_rs2d);
  assign fp_eq  = (fp_rs1d == fp_rs2d);
  assign fp_lt  = fp_s ? ($signed(fp_rs1d) < $signed(fp_rs2d)) : (fp_rs1d < fp_rs2d);

  cmp_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_lt(resp0_lt), .resp0_eq(resp0_eq),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_lt(resp1_lt), .resp1_eq(resp1_eq),
    .cmp_rs1d(cmp_rs1d), .cmp_rs2d(cmp_rs2d), .cmp_s(cmp_s), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  cmp_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
    .resp0_valid(fp_resp0_valid), .resp0_ready(resp0_ready), .resp0_lt(fp_resp0_lt), .resp0_eq(fp_resp0_eq),
    .resp1_valid(fp_resp1_valid), .resp1_ready(resp1_ready), .resp1_lt(fp_resp1_lt), .resp1_eq(fp_resp1_eq),
    .cmp_rs1d(fp_rs1d), .cmp_rs2d(fp_rs2d), .cmp_s(fp_s), .cmp_lt(fp_lt), .cmp_eq(fp_eq),
    .busy(fp_busy), .dbg_state_o(fp_dbg_state)
  );

  // Reference compare result {lt, eq} from the operand definitions.
  function automatic logic [1:0] ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic lt;
    if (s) lt = ($signed(a) < $signed(b));
    else   lt = (a < b);
    return {lt, (a == b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req0_ready: got %b want 0", req0_ready); end
    vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req1_ready: got %b want 0", req1_ready); end
    tick(); tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if ({resp0_valid, resp1_valid} !== 2'b00) begin miscompares++; $display("FAIL rst_resp_valid: got %b want 00", {resp0_valid, resp1_valid}); end
    vectors++; if ({resp0_lt, resp0_eq, resp1_lt, resp1_eq} !== 4'b0) begin miscompares++; $display("FAIL rst_resp_flags: got %b want 0000", {resp0_lt, resp0_eq, resp1_lt, resp1_eq}); end
    vectors++; if ({cmp_rs1d, cmp_rs2d, cmp_s} !== 65'd0) begin miscompares++; $display("FAIL rst_cmp_ops: got %h %h %b want 0", cmp_rs1d, cmp_rs2d, cmp_s); end
    vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    clear_inputs();
    reset_n = 1'b1;
  endtask

  // One req0 compare of 0xFFFFFFFF vs 1; resp0_ready is held high early and must be ignored.
  task automatic test_single(input logic s, input logic exp_lt);
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1; req0_s = s; resp0_ready = 1'b1;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0; req0_a = 32'h1234_5678; req0_s = ~s;
    #1;
    vectors++; if (cmp_s !== s) begin miscompares++; $display("FAIL single_cmp_s: got %b want %b", cmp_s, s); end
    vectors++; if ({cmp_rs1d, cmp_rs2d} !== {32'hFFFF_FFFF, 32'h1}) begin miscompares++; $display("FAIL single_cmp_ops: got %h %h", cmp_rs1d, cmp_rs2d); end
    vectors++; if ({busy, resp0_valid, resp1_valid} !== 3'b100) begin miscompares++; $display("FAIL single_eval: got busy/v0/v1 %b want 100", {busy, resp0_valid, resp1_valid}); end
    tick();
    vectors++; if ({resp0_valid, resp0_lt, resp0_eq, resp1_valid} !== {2'b11 & {1'b1, exp_lt}, 2'b00}) begin
      miscompares++; $display("FAIL single_resp: got v/lt/eq/v1 %b want %b", {resp0_valid, resp0_lt, resp0_eq, resp1_valid}, {1'b1, exp_lt, 2'b00});
    end
    tick();
    vectors++; if ({busy, resp0_valid, resp1_valid} !== 3'b000) begin miscompares++; $display("FAIL single_done: got %b want 000", {busy, resp0_valid, resp1_valid}); end
    vectors++; if ({cmp_rs1d, cmp_s} !== {32'hFFFF_FFFF, s}) begin miscompares++; $display("FAIL single_hold: got %h %b", cmp_rs1d, cmp_s); end
    clear_inputs();
  endtask

  task automatic test_arbitration();
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5; req0_s = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd7; req1_s = 1'b0;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL arb_first: got %b want 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    #1;
    vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL arb_eval_ready1: got %b want 0", req1_ready); end
    tick();
    vectors++; if ({resp0_valid, resp0_lt, resp0_eq} !== 3'b101) begin miscompares++; $display("FAIL arb_resp0: got %b want 101", {resp0_valid, resp0_lt, resp0_eq}); end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if ({resp0_valid, resp0_lt, resp0_eq, req1_ready, busy} !== 5'b10101) begin
        miscompares++; $display("FAIL arb_backpressure%0d: got v/lt/eq/rdy1/busy %b want 10101", k, {resp0_valid, resp0_lt, resp0_eq, req1_ready, busy});
      end
    end
    resp0_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    #1;
    vectors++; if ({busy, resp0_valid, req0_ready, req1_ready} !== 4'b0001) begin miscompares++; $display("FAIL arb_second_grant: got %b want 0001", {busy, resp0_valid, req0_ready, req1_ready}); end
    tick();
    req1_valid = 1'b0; resp1_ready = 1'b1;
    tick();
    vectors++; if ({resp1_valid, resp1_lt, resp1_eq, resp0_valid} !== 4'b1100) begin miscompares++; $display("FAIL arb_resp1: got %b want 1100", {resp1_valid, resp1_lt, resp1_eq, resp0_valid}); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL arb_idle: got %b want 0", busy); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_s = 1'b0; resp0_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b0; reset_n = 1'b0;
    #1;
    vectors++; if ({busy, req0_ready, req1_ready} !== 3'b000) begin miscompares++; $display("FAIL midrst_low: got busy/r0/r1 %b want 000", {busy, req0_ready, req1_ready}); end
    tick();
    reset_n = 1'b1;
    #1;
    vectors++; if ({busy, resp0_valid, resp1_valid, dbg_state} !== 5'b0) begin miscompares++; $display("FAIL midrst_after: got %b want 00000", {busy, resp0_valid, resp1_valid, dbg_state}); end
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL midrst_grant: got %b want 10", {req0_ready, req1_ready}); end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic lg, v0, v1, win, got;
    logic [1:0] exp;
    int cycles, bp;
    logic [31:0] edge_vals [4];
    edge_vals[0] = 32'h0; edge_vals[1] = 32'hFFFF_FFFF; edge_vals[2] = 32'h8000_0000; edge_vals[3] = 32'h7FFF_FFFF;
    do_reset();
    lg = 1'b1;
    for (int t = 0; t < 60; t++) begin
      {v1, v0} = 2'($urandom_range(1, 3));
      req0_valid = v0; req1_valid = v1;
      req0_a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      req1_a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
      req0_s = 1'($urandom_range(0, 1)); req1_s = 1'($urandom_range(0, 1));
      resp0_ready = 1'b0; resp1_ready = 1'b0;
      win = (v0 && v1) ? ~lg : v1;
      #1;
      vectors++; if ({req1_ready, req0_ready} !== {win, ~win}) begin miscompares++; $display("FAIL rnd_grant t%0d: got r1r0 %b want %b", t, {req1_ready, req0_ready}, {win, ~win}); end
      tick();
      lg = win;
      exp_q.push_back(win ? ref_cmp(req1_a, req1_b, req1_s) : ref_cmp(req0_a, req0_b, req0_s));
      req0_valid = 1'b1; req1_valid = 1'b1;
      cycles = 0; got = 1'b0;
      while (!got && cycles < 6) begin
        tick();
        cycles++;
        got = win ? resp1_valid : resp0_valid;
      end
      vectors++; if (cycles !== 1) begin miscompares++; $display("FAIL rnd_latency t%0d: got %0d cycles want 1", t, cycles); end
      exp = exp_q.pop_front();
      vectors++; if ((win ? {resp1_lt, resp1_eq, resp0_valid} : {resp0_lt, resp0_eq, resp1_valid}) !== {exp, 1'b0}) begin
        miscompares++; $display("FAIL rnd_result t%0d: got lt/eq/other %b want %b", t, win ? {resp1_lt, resp1_eq, resp0_valid} : {resp0_lt, resp0_eq, resp1_valid}, {exp, 1'b0});
      end
      bp = $urandom_range(0, 3);
      if (win) resp0_ready = 1'($urandom_range(0, 1)); else resp1_ready = 1'($urandom_range(0, 1));
      for (int k = 0; k < bp; k++) begin
        tick();
        vectors++; if ({req0_ready, req1_ready, busy, (win ? {resp1_valid, resp1_lt, resp1_eq} : {resp0_valid, resp0_lt, resp0_eq})} !== {3'b001, 1'b1, exp}) begin
          miscompares++; $display("FAIL rnd_hold t%0d: got r0/r1/busy/v/lt/eq %b want %b", t, {req0_ready, req1_ready, busy, (win ? {resp1_valid, resp1_lt, resp1_eq} : {resp0_valid, resp0_lt, resp0_eq})}, {3'b001, 1'b1, exp});
        end
      end
      if (win) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      vectors++; if ({busy, resp0_valid, resp1_valid} !== 3'b000) begin miscompares++; $display("FAIL rnd_retire t%0d: got %b want 000", t, {busy, resp0_valid, resp1_valid}); end
    end
    clear_inputs();
  endtask

  // Both requesters always valid, responses accepted at once: req0 wins every third cycle.
  task automatic test_fixed_prio();
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      #1;
      vectors++; if ({fp_req0_ready, fp_req1_ready, fp_resp0_valid, fp_resp1_valid} !== {(c % 3 == 0), 1'b0, (c % 3 == 2), 1'b0}) begin
        miscompares++; $display("FAIL fp_cycle%0d: got r0/r1/v0/v1 %b want %b", c, {fp_req0_ready, fp_req1_ready, fp_resp0_valid, fp_resp1_valid}, {(c % 3 == 0), 1'b0, (c % 3 == 2), 1'b0});
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single(1'b1, 1'b1);
    test_single(1'b0, 1'b0);
    test_arbitration();
    test_reset_mid();
    test_random();
    test_fixed_prio();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
